toggle_capture: RTL

TOGGLE_CAPTURE -- requirements
Module: toggle_capture

---
 rtl/toggle_pkg.sv | 19 +
 rtl/toggle_capture_if.sv | 31 +++
 rtl/evt_fifo.sv | 65 ++++++
 rtl/toggle_capture.sv | 104 ++++++++++
 4 files changed

// File: rtl/toggle_pkg.sv
// Shared constants for the toggle_capture block.
//   WIDTH_DEF  : default number of monitored bits
//   CNT_W_DEF  : default toggle counter width
//   DEPTH_DEF  : default event FIFO depth (power of two, >= 2)
//   REC_W_DEF  : default change-record width ({curr, chg})
//   rec_width(): record width for an arbitrary monitored width
package toggle_pkg;

  localparam int unsigned WIDTH_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;
  localparam int unsigned DEPTH_DEF = 2;
  localparam int unsigned REC_W_DEF = 2 * WIDTH_DEF;

  // A record carries the sampled vector plus its changed-bit mask.
  function automatic int unsigned rec_width(input int unsigned width);
    return 2 * width;
  endfunction

endpackage

// File: rtl/toggle_capture_if.sv
// Change-record stream between toggle_capture (master) and its consumer (slave).
//   evt_valid : head record present
//   evt_ready : consumer accepts the head record
//   evt_curr  : sampled vector of the head record
//   evt_chg   : changed-bit mask of the head record
interface toggle_capture_if
  import toggle_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF
);

  logic             evt_valid;
  logic             evt_ready;
  logic [WIDTH-1:0] evt_curr;
  logic [WIDTH-1:0] evt_chg;

  modport master (
    output evt_valid,
    output evt_curr,
    output evt_chg,
    input  evt_ready
  );

  modport slave (
    input  evt_valid,
    input  evt_curr,
    input  evt_chg,
    output evt_ready
  );

endinterface

// File: rtl/evt_fifo.sv
// Small synchronous FIFO holding change records.
//   clk, rst : clock and synchronous active-high reset
//   push     : write request (accepted if not full, or if a pop happens this cycle)
//   pop      : read request (ignored when empty)
//   wdata    : record to write
//   rdata    : head record (stable but meaningless when empty)
//   full     : DEPTH records held
//   empty    : no records held
module evt_fifo
  import toggle_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned DW    = REC_W_DEF
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic          pop,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata,
  output logic          full,
  output logic          empty
);

  localparam int unsigned IW = $clog2(DEPTH);
  localparam int unsigned PW = IW + 1;

  // Pointers carry an extra wrap bit to tell full from empty.
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [DW-1:0] mem_q [DEPTH];
  logic          do_push, do_pop;

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[IW-1:0] == rd_ptr_q[IW-1:0]) && (wr_ptr_q[IW] != rd_ptr_q[IW]);

  // A pop frees the slot the same cycle, so a push into a full FIFO still lands.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (!rst && do_push) mem_q[wr_ptr_q[IW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[IW-1:0]];

endmodule

// File: rtl/toggle_capture.sv
// Monitors a bit vector, records every change into an event FIFO, counts toggles
// and provides a registered OR of selected bits.
//   clk, rst  : clock and synchronous active-high reset
//   b_vec     : monitored vector
//   sel_mask  : bits contributing to or_sel
//   or_sel    : registered |(b_vec & sel_mask)
//   evt       : change-record stream (master side)
//   tog_cnt   : saturating total of bit toggles
//   ovf       : sticky, set when a record is dropped on a full FIFO
module toggle_capture
  import toggle_pkg::*;
#(
  parameter int unsigned WIDTH = WIDTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] b_vec,
  input  logic [WIDTH-1:0] sel_mask,
  output logic             or_sel,
  toggle_capture_if.master evt,
  output logic [CNT_W-1:0] tog_cnt,
  output logic             ovf
);

  localparam int unsigned RecW = rec_width(WIDTH);
  localparam int unsigned PcW  = $clog2(WIDTH + 1);
  localparam int unsigned SumW = ((CNT_W > PcW) ? CNT_W : PcW) + 1;

  localparam logic [0:0] StUnprimed = 1'b0;
  localparam logic [0:0] StRun      = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [WIDTH-1:0] prev_q;
  logic [CNT_W-1:0] tog_cnt_q, tog_cnt_d;
  logic             ovf_q, ovf_d;
  logic             or_sel_q;

  logic [WIDTH-1:0] chg;
  logic [PcW-1:0]   pop_cnt;
  logic [SumW-1:0]  cnt_sum;
  logic             push, pop, drop;
  logic             fifo_full, fifo_empty;
  logic [RecW-1:0]  rec_rdata;

  // prev is meaningless until one sample has been taken after reset.
  assign state_d = StRun;
  assign chg     = (state_q == StRun) ? (b_vec ^ prev_q) : '0;

  always_comb begin
    pop_cnt = '0;
    for (int i = 0; i < WIDTH; i++) pop_cnt = pop_cnt + PcW'(chg[i]);
  end

  always_comb begin
    cnt_sum   = SumW'(tog_cnt_q) + SumW'(pop_cnt);
    tog_cnt_d = (cnt_sum > SumW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : CNT_W'(cnt_sum);
  end

  assign push  = |chg;
  assign pop   = evt.evt_valid && evt.evt_ready;
  assign drop  = push && fifo_full && !pop;
  assign ovf_d = ovf_q | drop;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StUnprimed;
      prev_q    <= '0;
      tog_cnt_q <= '0;
      ovf_q     <= 1'b0;
      or_sel_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      prev_q    <= b_vec;
      tog_cnt_q <= tog_cnt_d;
      ovf_q     <= ovf_d;
      or_sel_q  <= |(b_vec & sel_mask);
    end
  end

  evt_fifo #(
    .DEPTH (DEPTH),
    .DW    (RecW)
  ) u_evt_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .wdata ({b_vec, chg}),
    .rdata (rec_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign evt.evt_valid = !fifo_empty;
  assign evt.evt_curr  = rec_rdata[RecW-1:WIDTH];
  assign evt.evt_chg   = rec_rdata[WIDTH-1:0];

  assign tog_cnt = tog_cnt_q;
  assign ovf     = ovf_q;
  assign or_sel  = or_sel_q;

endmodule
